load_store_unit: RTL and testbench

Memory-access stage between the pipeline's MEM stage and the data memory. It accepts one load or store request at a time: byte, halfword or word, with optional sign extension. Sub-word stores become a read-modify-write of the containing word, because the data memory only writes full words. Loads return a zero- or sign-extended value. Misaligned accesses and read timeouts are reported as errors.

---
 rtl/load_store_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store stage between MEM and a
// word-only data memory. Sub-word stores are performed as read-modify-write;
// loads are zero- or sign-extended. Misalignment and read timeouts are errors.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [1:0]  ReqSize,
   input  logic        ReqSigned,
   input  logic [31:0] ReqAddr,
   input  logic [31:0] ReqWData,
   output logic        RespValid,
   output logic [31:0] RespData,
   output logic        RespError,
   output logic        MemReadValid,
   output logic [31:0] MemReadAddr,
   input  logic [31:0] MemReadData,
   input  logic        MemReadReady,
   output logic        MemWriteValid,
   output logic [31:0] MemWriteAddr,
   output logic [31:0] MemWriteData
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD     = 3'd1,
      S_RMW_RD = 3'd2,
      S_RMW_WR = 3'd3,
      S_WR     = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   // The wait counter is compared against this limit; a read is abandoned
   // after TIMEOUT_CYCLES+1 unanswered read cycles.
   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [31:0] r_addr;
   logic [15:0] r_wdata;
   logic [31:0] r_wr_word;
   logic [7:0]  r_cnt;
   logic [31:0] r_resp_data;
   logic        r_resp_err;
   logic        w_timeout;
   logic        w_req_misaligned;
   logic        w_rd_state;
   logic        w_wr_state;

   // Half needs addr[0]=0, word needs addr[1:0]=0, size 3 is always rejected.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = lane[0];
         2'd2:    bad = (lane != 2'd0);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Select the addressed little-endian field of a word and extend it.
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'd0:    res = {{24{sgn & b[7]}}, b};
         2'd1:    res = {{16{sgn & h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Replace the addressed byte or half of a word with right-aligned store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wd,
                                               input logic [1:0] lane, input logic is_half);
      logic [31:0] res;
      res = word;
      if (is_half) begin
         if (lane[1]) begin
            res[31:16] = wd;
         end else begin
            res[15:0] = wd;
         end
      end else begin
         case (lane)
            2'd0:    res[7:0]   = wd[7:0];
            2'd1:    res[15:8]  = wd[7:0];
            2'd2:    res[23:16] = wd[7:0];
            default: res[31:24] = wd[7:0];
         endcase
      end
      return res;
   endfunction

   assign w_timeout        = (r_cnt == TO_LIMIT);
   assign w_req_misaligned = is_misaligned(ReqSize, ReqAddr[1:0]);
   assign w_rd_state       = (r_state == S_RD) || (r_state == S_RMW_RD);
   assign w_wr_state       = (r_state == S_WR) || (r_state == S_RMW_WR);

   // Memory and handshake outputs are pure decodes of registered state.
   assign ReqReady      = (r_state == S_IDLE);
   assign RespValid     = (r_state == S_RESP);
   assign RespData      = r_resp_data;
   assign RespError     = r_resp_err;
   assign MemReadValid  = w_rd_state;
   assign MemReadAddr   = w_rd_state ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
   assign MemWriteValid = w_wr_state;
   assign MemWriteAddr  = w_wr_state ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
   assign MemWriteData  = w_wr_state ? r_wr_word : 32'h0000_0000;

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (!ReqValid) begin
               w_next = S_IDLE;
            end else if (w_req_misaligned) begin
               w_next = S_RESP;
            end else if (!ReqWrite) begin
               w_next = S_RD;
            end else if (ReqSize == 2'd2) begin
               w_next = S_WR;
            end else begin
               w_next = S_RMW_RD;
            end
         end
         S_RD: begin
            if (MemReadReady || w_timeout) begin
               w_next = S_RESP;
            end else begin
               w_next = S_RD;
            end
         end
         S_RMW_RD: begin
            if (MemReadReady) begin
               w_next = S_RMW_WR;
            end else if (w_timeout) begin
               w_next = S_RESP;
            end else begin
               w_next = S_RMW_RD;
            end
         end
         S_RMW_WR: w_next = S_RESP;
         S_WR:     w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Request latch, wait counter, write-word build and response registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_size      <= 2'd0;
         r_signed    <= 1'b0;
         r_addr      <= 32'h0000_0000;
         r_wdata     <= 16'h0000;
         r_wr_word   <= 32'h0000_0000;
         r_cnt       <= 8'd0;
         r_resp_data <= 32'h0000_0000;
         r_resp_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ReqValid) begin
                  r_size    <= ReqSize;
                  r_signed  <= ReqSigned;
                  r_addr    <= ReqAddr;
                  r_wdata   <= ReqWData[15:0];
                  r_wr_word <= ReqWData;
                  r_cnt     <= 8'd0;
                  if (w_req_misaligned) begin
                     r_resp_data <= 32'h0000_0000;
                     r_resp_err  <= 1'b1;
                  end
               end
            end
            S_RD: begin
               if (MemReadReady) begin
                  r_resp_data <= load_extract(MemReadData, r_addr[1:0], r_size, r_signed);
                  r_resp_err  <= 1'b0;
               end else if (w_timeout) begin
                  r_resp_data <= 32'h0000_0000;
                  r_resp_err  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RMW_RD: begin
               if (MemReadReady) begin
                  r_wr_word <= store_merge(MemReadData, r_wdata, r_addr[1:0], (r_size == 2'd1));
               end else if (w_timeout) begin
                  r_resp_data <= 32'h0000_0000;
                  r_resp_err  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RMW_WR, S_WR: begin
               r_resp_data <= 32'h0000_0000;
               r_resp_err  <= 1'b0;
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a word memory model whose
// read-ready can be stalled or held low.
module tb_load_store_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic        ReqWrite = 1'b0;
   logic [1:0]  ReqSize = 2'd0;
   logic        ReqSigned = 1'b0;
   logic [31:0] ReqAddr = 32'h0;
   logic [31:0] ReqWData = 32'h0;
   logic        RespValid;
   logic [31:0] RespData;
   logic        RespError;
   logic        MemReadValid;
   logic [31:0] MemReadAddr;
   logic [31:0] MemReadData;
   logic        MemReadReady;
   logic        MemWriteValid;
   logic [31:0] MemWriteAddr;
   logic [31:0] MemWriteData;

   int checks = 0;
   int errors = 0;

   // memory model state
   logic [31:0] mem [0:63];
   logic        hold_low = 1'b0;
   int          stall_req = 0;
   int          stall_seen = 0;
   int          rd_pulses = 0;
   int          wr_pulses = 0;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .CLK(CLK), .RST(RST),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
      .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
      .RespValid(RespValid), .RespData(RespData), .RespError(RespError),
      .MemReadValid(MemReadValid), .MemReadAddr(MemReadAddr), .MemReadData(MemReadData),
      .MemReadReady(MemReadReady), .MemWriteValid(MemWriteValid),
      .MemWriteAddr(MemWriteAddr), .MemWriteData(MemWriteData)
   );

   always #5 CLK = ~CLK;

   assign MemReadData  = mem[MemReadAddr[7:2]];
   assign MemReadReady = MemReadValid && !hold_low && (stall_seen >= stall_req);

   // Memory model: commits writes (even during reset), counts stalls and pulses.
   always @(posedge CLK) begin
      if (MemReadValid && !MemReadReady) stall_seen <= stall_seen + 1;
      else stall_seen <= 0;
      if (MemReadValid) rd_pulses <= rd_pulses + 1;
      if (MemWriteValid) begin
         wr_pulses <= wr_pulses + 1;
         mem[MemWriteAddr[7:2]] <= MemWriteData;
      end
   end

   // Issue one request and follow it to its response (bounded wait).
   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] data, output logic err,
                         output int nrd, output int nwr,
                         output logic rdy_at_accept, output logic busy_ok);
      int r0;
      int w0;
      @(posedge CLK); #1;
      rdy_at_accept = ReqReady;
      r0 = rd_pulses;
      w0 = wr_pulses;
      ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg;
      ReqAddr = addr; ReqWData = wd;
      @(posedge CLK); #1;
      ReqValid = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      data = 32'hxxxx_xxxx;
      err = 1'bx;
      while (RespValid !== 1'b1 && lat < 60) begin
         if (ReqReady !== 1'b0) busy_ok = 1'b0;
         @(posedge CLK); #1;
         lat++;
      end
      if (RespValid === 1'b1) begin
         data = RespData;
         err = RespError;
         if (ReqReady !== 1'b0) busy_ok = 1'b0;
      end
      nrd = rd_pulses - r0;
      nwr = wr_pulses - w0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ReqReady got %b want 1", ReqReady); end
      checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL reset_RespValid got %b want 0", RespValid); end
      checks++; if (RespData !== 32'h0) begin errors++; $display("FAIL reset_RespData got %h want 0", RespData); end
      checks++; if (RespError !== 1'b0) begin errors++; $display("FAIL reset_RespError got %b want 0", RespError); end
      checks++; if (MemReadValid !== 1'b0 || MemWriteValid !== 1'b0) begin
         errors++; $display("FAIL reset_mem_valids got rd=%b wr=%b want 0 0", MemReadValid, MemWriteValid); end
      checks++; if (MemReadAddr !== 32'h0 || MemWriteAddr !== 32'h0 || MemWriteData !== 32'h0) begin
         errors++; $display("FAIL reset_mem_buses got ra=%h wa=%h wd=%h want 0", MemReadAddr, MemWriteAddr, MemWriteData); end
      RST = 1'b0;
   endtask

   task automatic test_byte_loads();
      logic [31:0] exp_s [4];
      logic [31:0] exp_u [4];
      int lat, nrd, nwr;
      logic [31:0] d;
      logic e, rdy, busy;
      exp_s = '{32'hFFFF_FFA1, 32'hFFFF_FFF0, 32'h0000_0070, 32'hFFFF_FF80};
      exp_u = '{32'h0000_00A1, 32'h0000_00F0, 32'h0000_0070, 32'h0000_0080};
      // preload through a word store
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8070_F0A1, lat, d, e, nrd, nwr, rdy, busy);
      checks++; if (mem[4] !== 32'h8070_F0A1) begin errors++; $display("FAIL preload got %h want 8070f0a1", mem[4]); end
      for (int i = 0; i < 8; i++) begin
         do_req(1'b0, 2'd0, (i < 4), 32'h10 + 32'(i % 4), 32'h0, lat, d, e, nrd, nwr, rdy, busy);
         checks++; if (d !== ((i < 4) ? exp_s[i % 4] : exp_u[i % 4]) || e !== 1'b0) begin
            errors++; $display("FAIL byte_load_%0d got %h err %b want %h err 0", i, d, e,
                               (i < 4) ? exp_s[i % 4] : exp_u[i % 4]); end
         checks++; if (lat != 2 || nrd != 1) begin
            errors++; $display("FAIL byte_load_lat_%0d got lat %0d reads %0d want 2 1", i, lat, nrd); end
      end
   endtask

   task automatic test_half_store();
      int lat, nrd, nwr;
      logic [31:0] d;
      logic e, rdy, busy;
      do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF, lat, d, e, nrd, nwr, rdy, busy);
      checks++; if (lat != 3 || nrd != 1 || nwr != 1 || e !== 1'b0 || d !== 32'h0) begin
         errors++; $display("FAIL half_store got lat %0d rd %0d wr %0d err %b data %h want 3 1 1 0 0", lat, nrd, nwr, e, d); end
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, d, e, nrd, nwr, rdy, busy);
      checks++; if (d !== 32'hBEEF_F0A1 || lat != 2) begin
         errors++; $display("FAIL half_store_readback got %h lat %0d want beeff0a1 2", d, lat); end
      do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat, d, e, nrd, nwr, rdy, busy);
      checks++; if (d !== 32'hFFFF_BEEF) begin errors++; $display("FAIL half_load_signed got %h want ffffbeef", d); end
      do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, lat, d, e, nrd, nwr, rdy, busy);
      checks++; if (d !== 32'h0000_F0A1) begin errors++; $display("FAIL half_load_unsigned got %h want 0000f0a1", d); end
      // byte store into lane 1
      do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_5655, lat, d, e, nrd, nwr, rdy, busy);
      checks++; if (mem[4] !== 32'hBEEF_55A1 || lat != 3) begin
         errors++; $display("FAIL byte_store got %h lat %0d want beef55a1 3", mem[4], lat); end
   endtask

   task automatic test_back_to_back();
      int lat, nrd, nwr;
      logic [31:0] d;
      logic e, rdy, busy;
      do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, lat, d, e, nrd, nwr, rdy, busy);
      checks++; if (lat != 2 || nwr != 1 || nrd != 0 || e !== 1'b0) begin
         errors++; $display("FAIL word_store got lat %0d wr %0d rd %0d err %b want 2 1 0 0", lat, nwr, nrd, e); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL store_busy got ReqReady high while busy want low"); end
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, d, e, nrd, nwr, rdy, busy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", rdy); end
      checks++; if (d !== 32'hDEAD_BEEF || lat != 2) begin
         errors++; $display("FAIL b2b_load got %h lat %0d want deadbeef 2", d, lat); end
   endtask

   task automatic test_misaligned();
      int lat, nrd, nwr;
      logic [31:0] d;
      logic e, rdy, busy;
      logic        wr_t [3];
      logic [1:0]  sz_t [3];
      logic [31:0] ad_t [3];
      wr_t = '{1'b0, 1'b1, 1'b0};
      sz_t = '{2'd1, 2'd2, 2'd3};
      ad_t = '{32'h21, 32'h22, 32'h20};
      for (int i = 0; i < 3; i++) begin
         do_req(wr_t[i], sz_t[i], 1'b1, ad_t[i], 32'hFFFF_FFFF, lat, d, e, nrd, nwr, rdy, busy);
         checks++; if (lat != 1 || e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL misaligned_%0d got lat %0d err %b data %h want 1 1 0", i, lat, e, d); end
         checks++; if (nrd != 0 || nwr != 0) begin
            errors++; $display("FAIL misaligned_mem_%0d got rd %0d wr %0d want 0 0", i, nrd, nwr); end
      end
   endtask

   task automatic test_timeout();
      int lat, nrd, nwr;
      logic [31:0] d;
      logic e, rdy, busy;
      hold_low = 1'b1;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, d, e, nrd, nwr, rdy, busy);
      hold_low = 1'b0;
      checks++; if (lat != 6 || e !== 1'b1 || d !== 32'h0) begin
         errors++; $display("FAIL timeout got lat %0d err %b data %h want 6 1 0", lat, e, d); end
      checks++; if (nrd != 5) begin errors++; $display("FAIL timeout_reads got %0d want 5", nrd); end
      stall_req = 2;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, d, e, nrd, nwr, rdy, busy);
      stall_req = 0;
      checks++; if (lat != 4 || e !== 1'b0 || d !== 32'hBEEF_55A1) begin
         errors++; $display("FAIL stall2 got lat %0d err %b data %h want 4 0 beef55a1", lat, e, d); end
   endtask

   task automatic test_reset_mid_op();
      int lat, nrd, nwr, w0;
      logic [31:0] d;
      logic e, rdy, busy;
      logic seen_resp;
      hold_low = 1'b1;
      w0 = wr_pulses;
      @(posedge CLK); #1;
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqSigned = 1'b0;
      ReqAddr = 32'h10; ReqWData = 32'h0000_0011;
      @(posedge CLK); #1;
      ReqValid = 1'b0;
      @(posedge CLK); #1;
      checks++; if (MemReadValid !== 1'b1) begin errors++; $display("FAIL rmw_stall_read got %b want 1", MemReadValid); end
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      hold_low = 1'b0;
      checks++; if (ReqReady !== 1'b1 || RespValid !== 1'b0 || MemReadValid !== 1'b0) begin
         errors++; $display("FAIL midreset_state got rdy %b resp %b rd %b want 1 0 0", ReqReady, RespValid, MemReadValid); end
      seen_resp = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (RespValid !== 1'b0) seen_resp = 1'b1;
         @(posedge CLK); #1;
      end
      checks++; if (seen_resp !== 1'b0 || wr_pulses != w0) begin
         errors++; $display("FAIL midreset_no_resp got resp %b writes %0d want 0 0", seen_resp, wr_pulses - w0); end
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, d, e, nrd, nwr, rdy, busy);
      checks++; if (d !== 32'hBEEF_55A1) begin errors++; $display("FAIL midreset_mem got %h want beef55a1", d); end
   endtask

   initial begin
      test_reset();
      test_byte_loads();
      test_half_store();
      test_back_to_back();
      test_misaligned();
      test_timeout();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
